// File: rtl/pipe_pkg.sv
// ============================================================
// pipe_pkg : shared pipeline widths and control-bundle layout
// Rev 1.0
// ============================================================
`default_nettype none

package pipe_pkg;

   localparam int XLEN   = 32;
   localparam int CTRL_W = 12;
   localparam int REG_W  = 5;

   // Bit positions inside the decoded control bundle handed to EX
   localparam int CTRL_ALU_OP_LSB = 0;
   localparam int CTRL_ALU_OP_MSB = 3;
   localparam int CTRL_ALU_SRC    = 4;
   localparam int CTRL_REG_WRITE  = 5;
   localparam int CTRL_MEM_WRITE  = 6;
   localparam int CTRL_BRANCH     = 7;
   localparam int CTRL_JUMP       = 8;
   localparam int CTRL_WB_SEL_LSB = 9;
   localparam int CTRL_WB_SEL_MSB = 10;
   localparam int CTRL_LINK       = 11;

   localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================
// hazard_detect : load-use hazard between ID and a load in EX
// Rev 1.0
// ============================================================
`default_nettype none

module hazard_detect
   import pipe_pkg::*;
(
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             ex_valid,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rd,
   output logic             hazard
);

   logic rs1_match;
   logic rs2_match;

   assign rs1_match = id_uses_rs1 & (id_rs1 == ex_rd);
   assign rs2_match = id_uses_rs2 & (id_rs2 == ex_rd);

   // x0 is hard-wired, so a load targeting it never produces a dependency
   assign hazard = id_valid & ex_valid & ex_mem_read & (ex_rd != '0)
                 & (rs1_match | rs2_match);

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================
// id_ex_stage : ID->EX pipeline register with load-use bubble
// Rev 1.0
// ============================================================
`default_nettype none

module id_ex_stage #(
   parameter int XLEN   = pipe_pkg::XLEN,
   parameter int CTRL_W = pipe_pkg::CTRL_W,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic              id_uses_rs1,
   input  logic              id_uses_rs2,
   input  logic [4:0]        id_rd,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              id_mem_read,
   input  logic [XLEN-1:0]   id_rdata1,
   input  logic [XLEN-1:0]   id_rdata2,
   input  logic              flush,
   input  logic              ext_stall,
   output logic              stall_if_id,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_imm,
   output logic [XLEN-1:0]   ex_op1,
   output logic [XLEN-1:0]   ex_op2,
   output logic [4:0]        ex_rs1,
   output logic [4:0]        ex_rs2,
   output logic [4:0]        ex_rd,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic              ex_mem_read,
   output logic [CNT_W-1:0]  hazard_cnt
);

   logic hazard;

   hazard_detect u_hazard_detect (
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .ex_valid    (ex_valid),
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .hazard      (hazard)
   );

   // A redirect discards whatever IF/ID holds, so there is nothing to hold
   assign stall_if_id = (hazard | ext_stall) & ~flush;

   always_ff @(posedge clk) begin
      if (!rst) begin
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_imm      <= '0;
         ex_op1      <= '0;
         ex_op2      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_ctrl     <= CTRL_W'(pipe_pkg::CTRL_NOP);
         ex_mem_read <= 1'b0;
         hazard_cnt  <= '0;
      end else if (flush) begin
         ex_valid    <= 1'b0;
         ex_ctrl     <= CTRL_W'(pipe_pkg::CTRL_NOP);
         ex_mem_read <= 1'b0;
      end else if (ext_stall) begin
         ex_valid    <= ex_valid;
      end else if (hazard) begin
         // Bubble: data fields keep their old contents, only control is killed
         ex_valid    <= 1'b0;
         ex_ctrl     <= CTRL_W'(pipe_pkg::CTRL_NOP);
         ex_mem_read <= 1'b0;
         if (hazard_cnt != '1) begin
            hazard_cnt <= hazard_cnt + 1'b1;
         end
      end else begin
         ex_valid    <= id_valid;
         ex_pc       <= id_pc;
         ex_imm      <= id_imm;
         ex_op1      <= id_rdata1;
         ex_op2      <= id_rdata2;
         ex_rs1      <= id_rs1;
         ex_rs2      <= id_rs2;
         ex_rd       <= id_rd;
         ex_ctrl     <= id_valid ? id_ctrl : CTRL_W'(pipe_pkg::CTRL_NOP);
         ex_mem_read <= id_valid & id_mem_read;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================
// tb_id_ex_stage : scoreboard bench for the ID->EX register
// Rev 1.0
// ============================================================
`default_nettype none

module tb_id_ex_stage;

   localparam int XLEN   = 32;
   localparam int CTRL_W = 12;
   localparam int CNT_W  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              id_valid;
   logic [XLEN-1:0]   id_pc;
   logic [4:0]        id_rs1, id_rs2, id_rd;
   logic              id_uses_rs1, id_uses_rs2;
   logic [XLEN-1:0]   id_imm;
   logic [CTRL_W-1:0] id_ctrl;
   logic              id_mem_read;
   logic [XLEN-1:0]   id_rdata1, id_rdata2;
   logic              flush, ext_stall;
   logic              stall_if_id;
   logic              ex_valid;
   logic [XLEN-1:0]   ex_pc, ex_imm, ex_op1, ex_op2;
   logic [4:0]        ex_rs1, ex_rs2, ex_rd;
   logic [CTRL_W-1:0] ex_ctrl;
   logic              ex_mem_read;
   logic [CNT_W-1:0]  hazard_cnt;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
      .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_imm(id_imm),
      .id_ctrl(id_ctrl), .id_mem_read(id_mem_read), .id_rdata1(id_rdata1),
      .id_rdata2(id_rdata2), .flush(flush), .ext_stall(ext_stall),
      .stall_if_id(stall_if_id), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_imm(ex_imm), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rs1(ex_rs1),
      .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
      .ex_mem_read(ex_mem_read), .hazard_cnt(hazard_cnt)
   );

   // One entry per cycle: stall_if_id for that cycle's inputs, then the
   // EX registers as they stand after the following posedge.
   typedef struct {
      string             name;
      bit                chk_stall;
      bit                exp_stall;
      bit                chk_regs;
      bit                exp_valid;
      logic [CTRL_W-1:0] ctrl;
      bit                mr;
      logic [CNT_W-1:0]  cnt;
      bit                chk_data;
      logic [XLEN-1:0]   pc, imm, op1, op2;
      logic [4:0]        rs1, rs2, rd;
   } exp_t;

   exp_t sb[$];
   int   total  = 0;
   int   passed = 0;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   initial begin : monitor
      exp_t cur, prev;
      bit   have_prev;
      have_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (have_prev && prev.chk_regs) begin
            cmp({prev.name, ".ex_valid"},    32'(ex_valid),    32'(prev.exp_valid));
            cmp({prev.name, ".ex_ctrl"},     32'(ex_ctrl),     32'(prev.ctrl));
            cmp({prev.name, ".ex_mem_read"}, 32'(ex_mem_read), 32'(prev.mr));
            cmp({prev.name, ".hazard_cnt"},  32'(hazard_cnt),  32'(prev.cnt));
            if (prev.chk_data) begin
               cmp({prev.name, ".ex_pc"},  ex_pc,  prev.pc);
               cmp({prev.name, ".ex_imm"}, ex_imm, prev.imm);
               cmp({prev.name, ".ex_op1"}, ex_op1, prev.op1);
               cmp({prev.name, ".ex_op2"}, ex_op2, prev.op2);
               cmp({prev.name, ".ex_rs1"}, 32'(ex_rs1), 32'(prev.rs1));
               cmp({prev.name, ".ex_rs2"}, 32'(ex_rs2), 32'(prev.rs2));
               cmp({prev.name, ".ex_rd"},  32'(ex_rd),  32'(prev.rd));
            end
         end
         have_prev = 1'b0;
         if (sb.size() > 0) begin
            cur = sb.pop_front();
            if (cur.chk_stall)
               cmp({cur.name, ".stall_if_id"}, 32'(stall_if_id), 32'(cur.exp_stall));
            prev      = cur;
            have_prev = 1'b1;
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   function automatic exp_t mk(input string nm, input bit st);
      exp_t e;
      e.name      = nm;
      e.chk_stall = 1'b1;
      e.exp_stall = st;
      e.chk_regs  = 1'b0;
      e.chk_data  = 1'b0;
      return e;
   endfunction

   function automatic exp_t exp_bubble(input string nm, input bit st, input logic [CNT_W-1:0] cnt);
      exp_t e;
      e           = mk(nm, st);
      e.chk_regs  = 1'b1;
      e.exp_valid = 1'b0;
      e.ctrl      = '0;
      e.mr        = 1'b0;
      e.cnt       = cnt;
      return e;
   endfunction

   // Expected result of a normal load of the current ID inputs
   function automatic exp_t exp_load(input string nm, input bit st, input logic [CNT_W-1:0] cnt);
      exp_t e;
      e           = exp_bubble(nm, st, cnt);
      e.exp_valid = id_valid;
      e.ctrl      = id_valid ? id_ctrl : '0;
      e.mr        = id_valid & id_mem_read;
      e.chk_data  = 1'b1;
      e.pc        = id_pc;
      e.imm       = id_imm;
      e.op1       = id_rdata1;
      e.op2       = id_rdata2;
      e.rs1       = id_rs1;
      e.rs2       = id_rs2;
      e.rd        = id_rd;
      return e;
   endfunction

   task automatic set_id(input bit v, input logic [31:0] pc, input logic [4:0] rs1, input bit u1,
                         input logic [4:0] rs2, input bit u2, input logic [4:0] rd,
                         input logic [31:0] imm, input logic [11:0] ctrl, input bit mr,
                         input logic [31:0] d1, input logic [31:0] d2);
      id_valid = v; id_pc = pc; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2;
      id_uses_rs2 = u2; id_rd = rd; id_imm = imm; id_ctrl = ctrl; id_mem_read = mr;
      id_rdata1 = d1; id_rdata2 = d2;
   endtask

   task automatic issue(input exp_t e);
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin : driver
      exp_t e, held;
      rst = 1'b0; flush = 1'b0; ext_stall = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      issue(exp_bubble("reset0", 0, 0));
      issue(exp_bubble("reset1", 0, 0));
      rst = 1'b1;

      // pass-through
      set_id(1, 32'h100, 1, 1, 2, 1, 3, 32'h10, 12'h0A5, 0, 32'hDEAD0001, 32'd5);
      e = exp_bubble("pass", 0, 0);
      e.exp_valid = 1; e.ctrl = 12'h0A5; e.chk_data = 1;
      e.pc = 32'h100; e.imm = 32'h10; e.op1 = 32'hDEAD0001; e.op2 = 32'd5;
      e.rs1 = 1; e.rs2 = 2; e.rd = 3;
      issue(e);

      // lw x5 then add x6,x5,x1
      set_id(1, 32'h104, 1, 1, 0, 0, 5, 32'h4, 12'h011, 1, 32'h1000, 0);
      issue(exp_load("lw_x5", 0, 0));
      set_id(1, 32'h108, 5, 1, 1, 1, 6, 0, 12'h0A5, 0, 32'h55, 32'h66);
      issue(exp_bubble("loaduse", 1, 1));
      id_rdata1 = 32'h77;
      issue(exp_load("add_enters", 0, 1));

      // no false hazards: load into x0, then rs2 match with rs2 unused
      set_id(1, 32'h10C, 2, 1, 0, 0, 0, 0, 12'h011, 1, 32'h20, 0);
      issue(exp_load("lw_x0", 0, 1));
      set_id(1, 32'h110, 0, 1, 0, 1, 7, 0, 12'h0A5, 0, 0, 0);
      issue(exp_load("use_x0", 0, 1));
      set_id(1, 32'h114, 1, 1, 0, 0, 9, 32'h8, 12'h011, 1, 32'h30, 0);
      issue(exp_load("lw_x9", 0, 1));
      set_id(1, 32'h118, 3, 1, 9, 0, 10, 0, 12'h0A5, 0, 32'h9, 32'hA);
      issue(exp_load("rs2_unused", 0, 1));

      // flush beats ext_stall
      set_id(1, 32'h11C, 1, 1, 2, 1, 4, 0, 12'h0A5, 0, 1, 2);
      flush = 1'b1; ext_stall = 1'b1;
      issue(exp_bubble("flush_stall", 0, 1));
      flush = 1'b0; ext_stall = 1'b0;

      // ext_stall holds EX for three cycles, and a pending hazard is not counted
      set_id(1, 32'h120, 2, 1, 0, 0, 11, 32'hC, 12'h03C, 1, 32'hAAAA, 32'hBBBB);
      held = exp_load("lw_x11", 0, 1);
      issue(held);
      set_id(1, 32'h124, 11, 1, 0, 0, 20, 0, 12'h0A5, 0, 1, 2);
      ext_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         e = held;
         e.name = $sformatf("ext_stall%0d", i);
         e.exp_stall = 1'b1;
         issue(e);
      end
      ext_stall = 1'b0;
      issue(exp_bubble("loaduse2", 1, 2));
      issue(exp_load("user2_enters", 0, 2));

      // reset in the middle of a stall
      set_id(1, 32'h128, 1, 1, 0, 0, 12, 0, 12'h011, 1, 32'h40, 0);
      issue(exp_load("lw_x12", 0, 2));
      set_id(1, 32'h12C, 0, 0, 12, 1, 13, 0, 12'h0A5, 0, 3, 4);
      rst = 1'b0;
      issue(exp_bubble("rst_mid_stall", 1, 0));
      rst = 1'b1;
      issue(exp_load("after_rst", 0, 0));

      // chained loads: five load-use stalls saturate the 2-bit counter
      set_id(1, 32'h130, 1, 1, 0, 0, 13, 0, 12'h011, 1, 32'h50, 0);
      issue(exp_load("chain_lw0", 0, 0));
      for (int k = 0; k < 5; k++) begin
         set_id(1, 32'h134 + 32'(4 * k), 5'(13 + k), 1, 0, 0, 5'(14 + k), 0, 12'h011, 1,
                32'h60 + 32'(k), 0);
         issue(exp_bubble($sformatf("sat_bubble%0d", k), 1, (k >= 2) ? 2'd3 : 2'(k + 1)));
         issue(exp_load($sformatf("sat_load%0d", k), 0, (k >= 2) ? 2'd3 : 2'(k + 1)));
      end

      // invalid ID slot: no stall, control killed even with stale fields
      set_id(0, 32'h200, 18, 1, 18, 1, 21, 0, 12'hFFF, 1, 0, 0);
      issue(exp_load("id_invalid", 0, 3));

      e = mk("drain", 0);
      e.chk_stall = 1'b0;
      issue(e);
      repeat (2) @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
